// File: rtl/crc_scrubber_if.sv
// Memory-side bus of the CRC scrubber: request/grant plus read return.
// master: req, we, addr, wdata, wcrc out; gnt, rvalid, rdata, rcrc in.
interface crc_scrubber_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int POLYNOMIAL_BITS = 4,
  parameter int ADDR_WIDTH      = 4
);
  logic                       mem_req;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [POLYNOMIAL_BITS-1:0] mem_wcrc;
  logic                       mem_gnt;
  logic                       mem_rvalid;
  logic [DATA_WIDTH-1:0]      mem_rdata;
  logic [POLYNOMIAL_BITS-1:0] mem_rcrc;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wcrc,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_rcrc
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wcrc,
    output mem_gnt, mem_rvalid, mem_rdata, mem_rcrc
  );
endinterface

// File: rtl/crc_scrubber.sv
// Background CRC scrubber: reads each word, corrects single-bit errors.
// Ports: clk, rst, scrub_en, mem (bus), busy, err pulses/addr, counts, pass_done.
module crc_scrubber #(
  parameter int DATA_WIDTH      = 8,
  parameter int POLYNOMIAL_BITS = 4,
  parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL = 4'h3,
  parameter int ADDR_WIDTH      = 4,
  parameter int SCRUB_INTERVAL  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en,
  crc_scrubber_if.master        mem,
  output logic                  busy,
  output logic                  err_corrected,
  output logic                  err_uncorr,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [7:0]            corr_cnt,
  output logic [7:0]            uncorr_cnt,
  output logic                  pass_done
);
  localparam int DW = DATA_WIDTH;
  localparam int P  = POLYNOMIAL_BITS;
  localparam int CW = DW + P;
  localparam int IW = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [IW-1:0] CNT_LOAD = IW'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_REQ, S_RD_WAIT,
    S_CHECK, S_WR_REQ, S_NEXT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [P-1:0]    rcrc_q, rcrc_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [P-1:0]    wcrc_q, wcrc_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            errc_q, errc_d;
  logic            erru_q, erru_d;
  logic [ADDR_WIDTH-1:0] eaddr_q, eaddr_d;
  logic [7:0]      ccnt_q, ccnt_d;
  logic [7:0]      ucnt_q, ucnt_d;
  logic            pass_q, pass_d;

  logic [P-1:0]    syn;
  logic [CW-1:0]   hit;
  logic [CW-1:0]   cw_fix;
  logic [DW-1:0]   corr_data;
  logic [P-1:0]    corr_crc;
  logic            fix;
  logic            bad;

  // MSB-first division: returns d * x^P mod G.
  function automatic logic [P-1:0] crc_f(input logic [DW-1:0] d);
    logic [P-1:0] c;
    logic         fb;
    c = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[P-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ POLYNOMIAL;
    end
    return c;
  endfunction

  // Codeword layout {data, crc}: bit k<P is a CRC bit,
  // bit P+i is data bit i.
  always_comb begin
    syn       = crc_f(rdata_q) ^ rcrc_q;
    hit       = '0;
    for (int j = 0; j < P; j++)
      hit[j] = (syn == (P'(1) << j));
    for (int i = 0; i < DW; i++)
      hit[P+i] = (syn == crc_f(DW'(1) << i));
    fix       = $onehot(hit);
    bad       = (syn != '0) && !fix;
    cw_fix    = {rdata_q, rcrc_q} ^ hit;
    corr_data = cw_fix[CW-1:P];
    corr_crc  = crc_f(corr_data);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rcrc_d  = rcrc_q;
    wdata_d = wdata_q;
    wcrc_d  = wcrc_q;
    errc_d  = 1'b0;
    erru_d  = 1'b0;
    eaddr_d = eaddr_q;
    ccnt_d  = ccnt_q;
    ucnt_d  = ucnt_q;
    pass_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!scrub_en) state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_RD_REQ;
        else cnt_d = cnt_q - IW'(1);
      end
      S_RD_REQ: begin
        if (mem.mem_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d = mem.mem_rdata;
          rcrc_d  = mem.mem_rcrc;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        wdata_d = corr_data;
        wcrc_d  = corr_crc;
        state_d = S_NEXT;
        if (fix) begin
          errc_d  = 1'b1;
          eaddr_d = addr_q;
          if (ccnt_q != 8'hFF) ccnt_d = ccnt_q + 8'd1;
          state_d = S_WR_REQ;
        end else if (bad) begin
          erru_d  = 1'b1;
          eaddr_d = addr_q;
          if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
        end
      end
      S_WR_REQ: begin
        if (mem.mem_gnt) state_d = S_NEXT;
      end
      S_NEXT: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        pass_d = &addr_q;
        if (scrub_en) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Bus strobes are flops that follow the next state.
    req_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    we_d  = (state_d == S_WR_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      rcrc_q  <= '0;
      wdata_q <= '0;
      wcrc_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      errc_q  <= 1'b0;
      erru_q  <= 1'b0;
      eaddr_q <= '0;
      ccnt_q  <= '0;
      ucnt_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rcrc_q  <= rcrc_d;
      wdata_q <= wdata_d;
      wcrc_q  <= wcrc_d;
      req_q   <= req_d;
      we_q    <= we_d;
      errc_q  <= errc_d;
      erru_q  <= erru_d;
      eaddr_q <= eaddr_d;
      ccnt_q  <= ccnt_d;
      ucnt_q  <= ucnt_d;
      pass_q  <= pass_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wcrc  = wcrc_q;

  assign busy          = !(state_q inside {S_IDLE, S_WAIT});
  assign err_corrected = errc_q;
  assign err_uncorr    = erru_q;
  assign err_addr      = eaddr_q;
  assign corr_cnt      = ccnt_q;
  assign uncorr_cnt    = ucnt_q;
  assign pass_done     = pass_q;
endmodule

// File: tb/tb_crc_scrubber.sv
// Bench for crc_scrubber: memory responder, GF(2) reference model.
// Directed corners plus randomized passes; prints one summary line.
module tb_crc_scrubber;
  localparam int DW = 8;
  localparam int P  = 4;
  localparam int AW = 4;
  localparam int SI = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scrub_en = 1'b0;
  logic busy, err_corrected, err_uncorr, pass_done;
  logic [AW-1:0] err_addr;
  logic [7:0] corr_cnt, uncorr_cnt;

  logic gnt_r = 1'b0;
  logic rvalid_r = 1'b0;
  logic [DW-1:0] rdata_r = '0;
  logic [P-1:0] rcrc_r = '0;

  crc_scrubber_if #(.DATA_WIDTH(DW), .POLYNOMIAL_BITS(P),
    .ADDR_WIDTH(AW)) mem_if ();

  assign mem_if.mem_gnt    = gnt_r;
  assign mem_if.mem_rvalid = rvalid_r;
  assign mem_if.mem_rdata  = rdata_r;
  assign mem_if.mem_rcrc   = rcrc_r;

  crc_scrubber #(
    .DATA_WIDTH(DW), .POLYNOMIAL_BITS(P), .POLYNOMIAL(4'h3),
    .ADDR_WIDTH(AW), .SCRUB_INTERVAL(SI)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en),
    .mem(mem_if.master),
    .busy(busy), .err_corrected(err_corrected),
    .err_uncorr(err_uncorr), .err_addr(err_addr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ncomp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory contents and responder configuration
  logic [DW-1:0] md [N];
  logic [P-1:0]  mc [N];
  int g_min = 0, g_max = 0, l_min = 0, l_max = 0;
  bit block_wr = 0, noise = 0;

  int gcnt = 0, rd_lat = 0;
  bit rd_pend = 0, req_prev = 0;
  logic [AW-1:0] rd_a, h_addr;
  logic h_we;
  int rd_cnt = 0, wr_cnt = 0;
  int rd_log[$];
  logic [15:0] wr_log[$];

  always @(negedge clk) begin
    gnt_r = 1'b0;
    rvalid_r = 1'b0;
    if (rd_pend) begin
      if (rd_lat == 0) begin
        rvalid_r = 1'b1;
        rdata_r = md[rd_a];
        rcrc_r = mc[rd_a];
        rd_pend = 0;
      end else rd_lat--;
    end else if (noise && $urandom_range(3, 0) == 0) begin
      rvalid_r = 1'b1;
      rdata_r = DW'($urandom);
      rcrc_r = P'($urandom);
    end
    if (mem_if.mem_req) begin
      if (!req_prev) begin
        gcnt = (mem_if.mem_we && block_wr) ? 1000000
             : int'($urandom_range(g_max, g_min));
        h_addr = mem_if.mem_addr;
        h_we = mem_if.mem_we;
      end else begin
        chk("hold_addr", mem_if.mem_addr, h_addr);
        chk("hold_we", mem_if.mem_we, h_we);
      end
      if (gcnt == 0) begin
        gnt_r = 1'b1;
        if (mem_if.mem_we) begin
          md[mem_if.mem_addr] = mem_if.mem_wdata;
          mc[mem_if.mem_addr] = mem_if.mem_wcrc;
          wr_cnt++;
          wr_log.push_back({mem_if.mem_addr, mem_if.mem_wdata,
                            mem_if.mem_wcrc});
        end else begin
          rd_pend = 1;
          rd_lat = int'($urandom_range(l_max, l_min));
          rd_a = mem_if.mem_addr;
          rd_cnt++;
          rd_log.push_back(int'(mem_if.mem_addr));
        end
      end else gcnt--;
    end
    req_prev = mem_if.mem_req;
  end

  // Pulse monitor
  int corr_p = 0, unc_p = 0, pd_cnt = 0;
  int corr_alog[$];
  logic prev_c = 0, prev_u = 0, prev_pd = 0;
  always @(negedge clk) begin
    if (err_corrected) begin
      corr_p++;
      corr_alog.push_back(int'(err_addr));
      chk("corr_pulse_width", prev_c, 1'b0);
    end
    if (err_uncorr) begin
      unc_p++;
      chk("unc_pulse_width", prev_u, 1'b0);
    end
    if (pass_done) begin
      pd_cnt++;
      chk("pd_pulse_width", prev_pd, 1'b0);
    end
    prev_c = err_corrected;
    prev_u = err_uncorr;
    prev_pd = pass_done;
  end

  // Reference model: codeword {data,crc} taken as a polynomial mod G.
  function automatic logic [3:0] gf_mod(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int b = 11; b >= 4; b--)
      if (r[b]) r = r ^ (12'h013 << (b - 4));
    return r[3:0];
  endfunction

  function automatic logic [3:0] crc_of(input logic [7:0] d);
    return gf_mod({d, 4'h0});
  endfunction

  logic [DW-1:0] ed [N];
  logic [P-1:0]  ec [N];
  int exp_corr = 0, exp_unc = 0, exp_ea = 0, p_corr = 0, p_unc = 0;

  task automatic predict();
    logic [11:0] cw;
    logic [3:0] s;
    int nhit, pos;
    p_corr = 0;
    p_unc = 0;
    for (int a = 0; a < N; a++) begin
      ed[a] = md[a];
      ec[a] = mc[a];
      cw = {md[a], mc[a]};
      s = gf_mod(cw);
      nhit = 0;
      pos = 0;
      for (int k = 0; k < 12; k++)
        if (gf_mod(12'(1) << k) == s) begin
          nhit++;
          pos = k;
        end
      if (s != 0 && nhit == 1) begin
        cw[pos] = ~cw[pos];
        ed[a] = cw[11:4];
        ec[a] = crc_of(cw[11:4]);
        p_corr++;
        exp_corr = (exp_corr < 255) ? exp_corr + 1 : 255;
        exp_ea = a;
      end else if (s != 0) begin
        p_unc++;
        exp_unc = (exp_unc < 255) ? exp_unc + 1 : 255;
        exp_ea = a;
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clean_mem();
    for (int a = 0; a < N; a++) begin
      md[a] = DW'($urandom);
      mc[a] = crc_of(md[a]);
    end
  endtask

  // One full pass from address 0, then scrubbing is stopped in WAIT.
  task automatic run_pass(input string tag);
    int c0, u0, w0, pd0;
    bit done;
    predict();
    c0 = corr_p;
    u0 = unc_p;
    w0 = wr_cnt;
    pd0 = pd_cnt;
    rd_log.delete();
    wr_log.delete();
    corr_alog.delete();
    scrub_en = 1'b1;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      done = (pd_cnt != pd0);
    end
    chk({tag, "_timeout"}, done, 1'b1);
    scrub_en = 1'b0;
    tick(3);
    chk({tag, "_pd"}, pd_cnt - pd0, 1);
    chk({tag, "_corr_p"}, corr_p - c0, p_corr);
    chk({tag, "_unc_p"}, unc_p - u0, p_unc);
    chk({tag, "_writes"}, wr_cnt - w0, p_corr);
    chk({tag, "_corr_cnt"}, corr_cnt, exp_corr);
    chk({tag, "_unc_cnt"}, uncorr_cnt, exp_unc);
    chk({tag, "_err_addr"}, err_addr, exp_ea);
    chk({tag, "_reads"}, rd_log.size(), N);
    for (int i = 0; i < rd_log.size() && i < N; i++)
      chk({tag, "_rd_order"}, rd_log[i], i);
    for (int a = 0; a < N; a++)
      chk({tag, "_mem"}, {md[a], mc[a]}, {ed[a], ec[a]});
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int b_rd, b_wr, b_c, a;
    bit seen;
    logic [11:0] cw;

    // Reset state
    tick(3);
    chk("rst_req", mem_if.mem_req, 1'b0);
    chk("rst_we", mem_if.mem_we, 1'b0);
    chk("rst_wdata", mem_if.mem_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_errc", err_corrected, 1'b0);
    chk("rst_erru", err_uncorr, 1'b0);
    chk("rst_eaddr", err_addr, 4'h0);
    chk("rst_ccnt", corr_cnt, 8'h00);
    chk("rst_ucnt", uncorr_cnt, 8'h00);
    chk("rst_pd", pass_done, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("idle_req", mem_if.mem_req, 1'b0);

    // Directed pass: clean, data error, CRC-bit error, uncorrectable
    clean_mem();
    md[0] = 8'h00; mc[0] = 4'h0;
    md[2] = 8'h01; mc[2] = 4'h0;
    md[3] = 8'h00; mc[3] = 4'h4;
    md[4] = 8'h00; mc[4] = 4'h9;
    g_min = 0; g_max = 0; l_min = 0; l_max = 1;
    run_pass("p1");
    chk("p1_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("p1_wr0", wr_log[0], 16'h2000);
      chk("p1_wr1", wr_log[1], 16'h3000);
    end
    if (corr_alog.size() > 0) chk("p1_eaddr_first", corr_alog[0], 2);
    chk("p1_ccnt_lit", corr_cnt, 8'd2);
    chk("p1_ucnt_lit", uncorr_cnt, 8'd1);
    chk("p1_eaddr_lit", err_addr, 4'd4);

    // Grant held off 5 cycles; random 0/1/2-bit errors; rvalid noise
    for (int p = 0; p < 2; p++) begin
      clean_mem();
      for (int i = 0; i < N; i++) begin
        cw = {md[i], mc[i]};
        repeat ($urandom_range(2, 0))
          cw[$urandom_range(11, 0)] ^= 1'b1;
        md[i] = cw[11:4];
        mc[i] = cw[3:0];
      end
      if (p == 0) begin g_min = 5; g_max = 5; end
      else begin g_min = 0; g_max = 3; end
      l_min = 0; l_max = 3; noise = 1;
      run_pass($sformatf("rnd%0d", p));
    end

    // scrub_en dropped while the read is outstanding
    noise = 0;
    for (int i = 0; i < N; i++)
      md[i] = md[i] ^ (8'h01 << $urandom_range(7, 0));
    g_min = 0; g_max = 0; l_min = 6; l_max = 6;
    b_rd = rd_cnt; b_wr = wr_cnt; b_c = corr_p;
    scrub_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = (rd_cnt != b_rd);
    end
    chk("rdw_timeout", seen, 1'b1);
    scrub_en = 1'b0;
    chk("rdw_busy_on", busy, 1'b1);
    tick(40);
    chk("rdw_reads", rd_cnt - b_rd, 1);
    chk("rdw_writes", wr_cnt - b_wr, 1);
    chk("rdw_corr", corr_p - b_c, 1);
    chk("rdw_idle", busy, 1'b0);
    if (rd_log.size() > 0) begin
      a = rd_log[rd_log.size() - 1];
      chk("rdw_fixed", mc[a], crc_of(md[a]));
    end

    // Reset while a write waits for grant
    l_min = 0; l_max = 2; block_wr = 1;
    scrub_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = mem_if.mem_req && mem_if.mem_we;
    end
    chk("wrr_timeout", seen, 1'b1);
    rst = 1'b1;
    scrub_en = 1'b0;
    tick();
    chk("wrr_req", mem_if.mem_req, 1'b0);
    chk("wrr_busy", busy, 1'b0);
    chk("wrr_ccnt", corr_cnt, 8'h00);
    chk("wrr_ucnt", uncorr_cnt, 8'h00);
    chk("wrr_eaddr", err_addr, 4'h0);
    chk("wrr_errc", err_corrected, 1'b0);
    tick(2);
    rst = 1'b0;
    block_wr = 0;
    exp_corr = 0; exp_unc = 0; exp_ea = 0;
    tick(2);

    // 19 passes of 16 correctable errors: counter saturates
    noise = 1;
    g_min = 0; g_max = 1; l_min = 0; l_max = 1;
    for (int p = 0; p < 19; p++) begin
      clean_mem();
      for (int i = 0; i < N; i++) begin
        cw = {md[i], mc[i]};
        cw[$urandom_range(11, 0)] ^= 1'b1;
        md[i] = cw[11:4];
        mc[i] = cw[3:0];
      end
      run_pass($sformatf("sat%0d", p));
    end
    chk("sat_ccnt", corr_cnt, 8'd255);
    chk("sat_ucnt", uncorr_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end
endmodule

// File: doc/crc_scrubber.md
CRC_SCRUBBER -- requirements
Module: crc_scrubber

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of a protected data word.
REQ-002 Parameter POLYNOMIAL_BITS, default 4, CRC width P.
REQ-003 Parameter POLYNOMIAL, default 4'h3, CRC generator polynomial without the implicit x^P term.
REQ-004 Parameter ADDR_WIDTH, default 4, memory address width; memory depth is 2^ADDR_WIDTH.
REQ-005 Parameter SCRUB_INTERVAL, default 256, idle cycles between word scrubs; minimum 1.
REQ-006 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port scrub_en, input, 1, enables background scrubbing.
REQ-009 Port mem_req, output, 1, memory access request.
REQ-010 Port mem_we, output, 1, 1 = write, 0 = read; valid while mem_req=1.
REQ-011 Port mem_addr, output, ADDR_WIDTH, access address.
REQ-012 Port mem_wdata, output, DATA_WIDTH, write data.
REQ-013 Port mem_wcrc, output, POLYNOMIAL_BITS, write CRC.
REQ-014 Port mem_gnt, input, 1, memory accepts the request in the current cycle.
REQ-015 Port mem_rvalid, input, 1, read data valid; arrives one or more cycles after read grant.
REQ-016 Port mem_rdata, input, DATA_WIDTH, read data.
REQ-017 Port mem_rcrc, input, POLYNOMIAL_BITS, stored CRC of the read word.
REQ-018 Port busy, output, 1, FSM outside IDLE and WAIT.
REQ-019 Port err_corrected, output, 1, single-cycle pulse: correctable error found.
REQ-020 Port err_uncorr, output, 1, single-cycle pulse: uncorrectable error found.
REQ-021 Port err_addr, output, ADDR_WIDTH, address of the most recent error of either kind.
REQ-022 Port corr_cnt, output, 8, saturating count of correctable errors.
REQ-023 Port uncorr_cnt, output, 8, saturating count of uncorrectable errors.
REQ-024 Port pass_done, output, 1, single-cycle pulse when the last address completes.

Function
REQ-025 CRC definition: MSB-first, init 0, no reflection, no final XOR; crc(d) = d*x^P mod G.
REQ-026 Syndrome S = crc(mem_rdata) XOR mem_rcrc, computed combinationally on captured data.
REQ-027 Error classification: S=0 means no error; S matches exactly one of the DATA_WIDTH+P single-bit syndromes means correctable; otherwise uncorrectable.
REQ-028 Single-bit syndromes: data bit i maps to x^(i+P) mod G; CRC bit j maps to 1<<j.
REQ-029 FSM states: IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
REQ-030 IDLE: when scrub_en=1, load the interval counter with SCRUB_INTERVAL-1 and go to WAIT.
REQ-031 WAIT: decrement each cycle; at 0 go to RD_REQ; if scrub_en=0, go to IDLE.
REQ-032 RD_REQ: mem_req=1, mem_we=0; hold address stable until mem_gnt, then go to RD_WAIT.
REQ-033 RD_WAIT: on mem_rvalid, capture rdata/rcrc and go to CHECK; mem_rvalid outside RD_WAIT is ignored.
REQ-034 CHECK lasts one cycle. Outcomes:
- no error: go to NEXT.
- correctable: pulse err_corrected, update err_addr, corr_cnt+1, go to WR_REQ.
- uncorrectable: pulse err_uncorr, update err_addr, uncorr_cnt+1, go to NEXT; no write.
REQ-035 WR_REQ: mem_req=1, mem_we=1; mem_wdata is the corrected data, mem_wcrc is crc(corrected data); hold until mem_gnt, then go to NEXT.
REQ-036 NEXT: address +1, wrapping from 2^ADDR_WIDTH-1 to 0; pulse pass_done on wrap; go to WAIT (reloaded) if scrub_en=1, else IDLE.
REQ-037 Deasserting scrub_en in RD_REQ through NEXT lets the current word complete; no access is abandoned.
REQ-038 Counters saturate at 255 and do not wrap.
REQ-039 mem_req is registered; it is 0 in every state except RD_REQ and WR_REQ.

Reset
REQ-040 While rst=1: state IDLE, address 0, interval counter 0, all outputs 0, both counters 0.
REQ-041 rst mid-access drops mem_req the next cycle; in-flight read data is discarded.

Verification (P=4, G=4'h3, DW=8, AW=4, SCRUB_INTERVAL=4)
REQ-042 Clean word: address 0 holds 0x00/crc 0x0 -> no pulses, no write, NEXT to address 1.
REQ-043 Data error: address 2 holds 0x01/crc 0x0 (S=0x3) -> err_corrected pulse, err_addr=2, write 0x00/crc 0x0, corr_cnt=1.
REQ-044 CRC-bit error: 0x00/crc 0x4 -> correctable; write 0x00/crc 0x0.
REQ-045 Uncorrectable: 0x00/crc 0x9 (S matches no position) -> err_uncorr pulse, no write, uncorr_cnt=1.
REQ-046 Handshake and wrap: mem_gnt held low 5 cycles, then high -> mem_req/addr stable throughout; after address 15, pass_done pulses and address returns to 0.
REQ-047 Control corners:
- scrub_en dropped in RD_WAIT -> word completes, then IDLE.
- rst during WR_REQ -> mem_req=0 next cycle, all state cleared.
- 300 injected errors -> counter holds at 255.
